// File: rtl/prio_encoder_rr_if.sv
// Request/result bundle for prio_encoder_rr.
// Consumer side drives READY; requester drives IN and EN.
interface prio_encoder_rr_if #(
  parameter int N = 8
);
  localparam int W = $clog2(N);

  logic [N-1:0] IN;
  logic         EN;
  logic         READY;
  logic [W-1:0] OUT;
  logic [N-1:0] ONEHOT;
  logic         V;

  modport master (
    output IN,
    output EN,
    output READY,
    input  OUT,
    input  ONEHOT,
    input  V
  );

  modport slave (
    input  IN,
    input  EN,
    input  READY,
    output OUT,
    output ONEHOT,
    output V
  );
endinterface

// File: rtl/prio_encoder_rr.sv
// Registered N-input priority encoder, fixed or round-robin,
// with a valid/ready result hold.
module prio_encoder_rr #(
  parameter int N  = 8,
  parameter int RR = 0
) (
  input logic CLK,
  input logic RST_N,
  prio_encoder_rr_if.slave bus
);
  localparam int W = $clog2(N);
  localparam logic [W-1:0] LAST = W'(N - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  logic [0:0]   state;
  logic [W-1:0] out_q;
  logic [N-1:0] oh_q;
  logic [W-1:0] p;

  logic         hs;
  logic         cap;
  logic [W-1:0] pnext;
  logic [W-1:0] s;
  logic [W-1:0] win;

  assign hs = (state == HOLD) && bus.READY;

  // pointer steps one below the accepted index, wrapping modulo N
  assign pnext = (out_q == '0) ? LAST : out_q - 1'b1;

  always_comb begin
    s = LAST;
    if (RR != 0) begin
      s = hs ? pnext : p;
    end
  end

  assign cap = bus.EN && (|bus.IN) &&
               ((state == IDLE) || hs);

  always_comb begin
    logic [W-1:0] idx;
    logic         found;
    win   = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = W'((int'(s) + N - k) % N);
      if (!found && bus.IN[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state <= IDLE;
      out_q <= '0;
      oh_q  <= '0;
      p     <= LAST;
    end else begin
      if ((RR != 0) && hs) begin
        p <= pnext;
      end
      if (cap) begin
        state <= HOLD;
        out_q <= win;
        oh_q  <= N'(1) << win;
      end else if (hs) begin
        state <= IDLE;
        out_q <= '0;
        oh_q  <= '0;
      end
    end
  end

  assign bus.OUT    = out_q;
  assign bus.ONEHOT = oh_q;
  assign bus.V      = (state == HOLD);
endmodule

// File: tb/tb_prio_encoder_rr.sv
// Bench for prio_encoder_rr: fixed (u0) and round-robin (u1)
// instances driven with identical stimulus.
module tb_prio_encoder_rr;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_s = '0;
  logic       en_s = 1'b0;
  logic       rdy_s = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  int mv[2];
  int mo[2];
  int mp[2];

  logic       o_v[2];
  logic [2:0] o_out[2];
  logic [7:0] o_oh[2];

  always #5 clk = ~clk;

  prio_encoder_rr_if #(.N(8)) b0 ();
  prio_encoder_rr_if #(.N(8)) b1 ();

  assign b0.IN = in_s;
  assign b0.EN = en_s;
  assign b0.READY = rdy_s;
  assign b1.IN = in_s;
  assign b1.EN = en_s;
  assign b1.READY = rdy_s;

  assign o_v[0] = b0.V;
  assign o_out[0] = b0.OUT;
  assign o_oh[0] = b0.ONEHOT;
  assign o_v[1] = b1.V;
  assign o_out[1] = b1.OUT;
  assign o_oh[1] = b1.ONEHOT;

  prio_encoder_rr #(.N(8), .RR(0)) u0 (
    .CLK(clk), .RST_N(rst_n), .bus(b0.slave)
  );
  prio_encoder_rr #(.N(8), .RR(1)) u1 (
    .CLK(clk), .RST_N(rst_n), .bus(b1.slave)
  );

  function automatic int winner(logic [7:0] r, int st);
    for (int k = 0; k < 8; k++) begin
      int i;
      i = (st - k + 8) % 8;
      if (r[i]) return i;
    end
    return 0;
  endfunction

  function automatic logic [11:0] exp_bus(int m);
    logic [7:0] oh;
    oh = (mv[m] != 0) ? (8'd1 << mo[m]) : 8'd0;
    return {(mv[m] != 0), 3'(mo[m]), oh};
  endfunction

  task automatic step(input logic r, input logic [7:0] i,
                      input logic e, input logic rd);
    @(negedge clk);
    rst_n = r;
    in_s = i;
    en_s = e;
    rdy_s = rd;
    @(posedge clk);
    for (int m = 0; m < 2; m++) begin
      if (!r) begin
        mv[m] = 0; mo[m] = 0; mp[m] = 7;
      end else begin
        bit hs, cp;
        int nxt, st;
        hs = (mv[m] != 0) && rd;
        nxt = (mo[m] == 0) ? 7 : mo[m] - 1;
        st = (m == 0) ? 7 : (hs ? nxt : mp[m]);
        cp = e && (i != 0) && ((mv[m] == 0) || hs);
        if (hs && m == 1) mp[m] = nxt;
        if (cp) begin
          mo[m] = winner(i, st); mv[m] = 1;
        end else if (hs) begin
          mo[m] = 0; mv[m] = 0;
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    repeat (2) begin
      step(0, 8'hFF, 1, 1);
      for (int m = 0; m < 2; m++) begin
        n_cmp++;
        if ({o_v[m], o_out[m], o_oh[m]} !== 12'h000) begin
          $display("FAIL reset dut%0d got %h want 000", m,
                   {o_v[m], o_out[m], o_oh[m]});
          n_bad++;
        end
      end
    end
    step(1, 8'hFF, 1, 0);
    for (int m = 0; m < 2; m++) begin
      n_cmp++;
      if ({o_v[m], o_out[m], o_oh[m]} !== {1'b1, 3'd7, 8'h80}) begin
        $display("FAIL reset_first dut%0d got %h want f80", m,
                 {o_v[m], o_out[m], o_oh[m]});
        n_bad++;
      end
    end
  endtask

  task automatic test_fixed_hold();
    step(0, 8'h00, 0, 0);
    step(1, 8'h2C, 1, 0);
    n_cmp++;
    if ({o_v[0], o_out[0], o_oh[0]} !== {1'b1, 3'd5, 8'h20}) begin
      $display("FAIL fixed_cap got %h want d20",
               {o_v[0], o_out[0], o_oh[0]});
      n_bad++;
    end
    repeat (3) begin
      step(1, 8'h01, 1, 0);
      n_cmp++;
      if (o_out[0] !== 3'd5 || o_v[0] !== 1'b1) begin
        $display("FAIL fixed_hold got out=%0d v=%b want 5/1",
                 o_out[0], o_v[0]);
        n_bad++;
      end
    end
    step(1, 8'h01, 1, 1);
    for (int m = 0; m < 2; m++) begin
      n_cmp++;
      if ({o_v[m], o_out[m], o_oh[m]} !== {1'b1, 3'd0, 8'h01}) begin
        $display("FAIL fixed_b2b dut%0d got %h want 801", m,
                 {o_v[m], o_out[m], o_oh[m]});
        n_bad++;
      end
    end
    step(1, 8'h00, 0, 1);
    for (int m = 0; m < 2; m++) begin
      n_cmp++;
      if ({o_v[m], o_out[m], o_oh[m]} !== 12'h000) begin
        $display("FAIL fixed_drain dut%0d got %h want 000", m,
                 {o_v[m], o_out[m], o_oh[m]});
        n_bad++;
      end
    end
  endtask

  task automatic test_rr_stream();
    step(0, 8'h00, 0, 0);
    for (int k = 0; k < 9; k++) begin
      int e1;
      step(1, 8'hFF, 1, 1);
      e1 = (7 - k + 8) % 8;
      n_cmp++;
      if (o_v[1] !== 1'b1 || o_out[1] !== 3'(e1)) begin
        $display("FAIL rr_stream k=%0d got out=%0d v=%b want %0d/1",
                 k, o_out[1], o_v[1], e1);
        n_bad++;
      end
      n_cmp++;
      if (o_v[0] !== 1'b1 || o_out[0] !== 3'd7) begin
        $display("FAIL fp_stream k=%0d got out=%0d v=%b want 7/1",
                 k, o_out[0], o_v[0]);
        n_bad++;
      end
    end
  endtask

  task automatic test_fairness();
    step(0, 8'h00, 0, 0);
    for (int k = 0; k < 4; k++) begin
      int e1;
      step(1, 8'h81, 1, 1);
      e1 = (k % 2 == 0) ? 7 : 0;
      n_cmp++;
      if (o_out[1] !== 3'(e1) || o_oh[1] !== 8'(1 << e1)) begin
        $display("FAIL rr_fair k=%0d got %0d/%h want %0d", k,
                 o_out[1], o_oh[1], e1);
        n_bad++;
      end
      n_cmp++;
      if (o_out[0] !== 3'd7) begin
        $display("FAIL fp_fair k=%0d got %0d want 7", k, o_out[0]);
        n_bad++;
      end
    end
  endtask

  task automatic test_empty();
    step(0, 8'h00, 0, 0);
    repeat (5) begin
      step(1, 8'h00, 1, 0);
      for (int m = 0; m < 2; m++) begin
        n_cmp++;
        if (o_v[m] !== 1'b0) begin
          $display("FAIL empty dut%0d got v=%b want 0", m, o_v[m]);
          n_bad++;
        end
      end
    end
    repeat (3) begin
      step(1, 8'hFF, 0, 1);
      for (int m = 0; m < 2; m++) begin
        n_cmp++;
        if ({o_v[m], o_out[m], o_oh[m]} !== 12'h000) begin
          $display("FAIL disabled dut%0d got %h want 000", m,
                   {o_v[m], o_out[m], o_oh[m]});
          n_bad++;
        end
      end
    end
    step(1, 8'hFF, 1, 0);
    for (int m = 0; m < 2; m++) begin
      n_cmp++;
      if (o_out[m] !== 3'd7 || o_v[m] !== 1'b1) begin
        $display("FAIL empty_next dut%0d got %0d/%b want 7/1", m,
                 o_out[m], o_v[m]);
        n_bad++;
      end
    end
  endtask

  task automatic test_reset_mid();
    step(0, 8'h00, 0, 0);
    step(1, 8'hFF, 1, 0);
    step(1, 8'hFF, 1, 1);
    step(1, 8'hFF, 1, 0);
    n_cmp++;
    if (o_out[1] !== 3'd6 || o_v[1] !== 1'b1) begin
      $display("FAIL mid_cap got %0d/%b want 6/1", o_out[1], o_v[1]);
      n_bad++;
    end
    step(0, 8'hFF, 1, 1);
    for (int m = 0; m < 2; m++) begin
      n_cmp++;
      if ({o_v[m], o_out[m], o_oh[m]} !== 12'h000) begin
        $display("FAIL mid_reset dut%0d got %h want 000", m,
                 {o_v[m], o_out[m], o_oh[m]});
        n_bad++;
      end
    end
    step(1, 8'hFF, 1, 0);
    for (int m = 0; m < 2; m++) begin
      n_cmp++;
      if (o_out[m] !== 3'd7 || o_v[m] !== 1'b1) begin
        $display("FAIL mid_after dut%0d got %0d/%b want 7/1", m,
                 o_out[m], o_v[m]);
        n_bad++;
      end
    end
  endtask

  task automatic test_random();
    step(0, 8'h00, 0, 0);
    for (int c = 0; c < 400; c++) begin
      logic       r, e, rd;
      logic [7:0] i;
      r = ($urandom_range(0, 59) != 0);
      i = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      e = ($urandom_range(0, 4) != 0);
      rd = $urandom_range(0, 1) != 0;
      step(r, i, e, rd);
      for (int m = 0; m < 2; m++) begin
        n_cmp++;
        if ({o_v[m], o_out[m], o_oh[m]} !== exp_bus(m)) begin
          $display("FAIL random c=%0d dut%0d got %h want %h", c, m,
                   {o_v[m], o_out[m], o_oh[m]}, exp_bus(m));
          n_bad++;
        end
      end
    end
  endtask

  initial begin
    for (int m = 0; m < 2; m++) begin
      mv[m] = 0; mo[m] = 0; mp[m] = 7;
    end
    test_reset();
    test_fixed_hold();
    test_rr_stream();
    test_fairness();
    test_empty();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
